mem_stage_ctrl: RTL and testbench

//  MEM pipeline stage, directly downstream of the EX/MEM register.

---
 rtl/mem_stage_ctrl_if.sv | 15 +
 rtl/mem_stage_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port between the MEM stage and a variable-latency memory.
// The master drives req/we/addr/wdata. The slave answers with ack and rdata.
interface mem_stage_ctrl_if #(
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: drives the data-memory handshake, stalls upstream while an
// access is outstanding, resolves PCSrc, and holds the MEM/WB register.
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_wb,
    input  logic [2:0]          i_m,
    input  logic                i_zero,
    input  logic [4:0]          i_rd,
    input  logic [DW-1:0]       i_alu_result,
    input  logic [DW-1:0]       i_write_data,
    mem_stage_ctrl_if.master    dmem,
    output logic                o_stall,
    output logic                o_pcsrc,
    output logic                o_bus_err,
    output logic [1:0]          o_wb,
    output logic [DW-1:0]       o_read_data,
    output logic [DW-1:0]       o_alu_result,
    output logic [4:0]          o_rd
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic          r_bus_err, w_set_err;

    // Holding registers for the access in flight.
    logic          r_we;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_wb;
    logic [4:0]    r_rd;
    logic          w_cap;

    logic [1:0]    r_wb_o;
    logic [DW-1:0] r_rdata_o;
    logic [DW-1:0] r_alu_o;
    logic [4:0]    r_rd_o;

    logic [1:0]    w_mw_wb;
    logic [DW-1:0] w_mw_rdata;
    logic [DW-1:0] w_mw_alu;
    logic [4:0]    w_mw_rd;

    logic          w_req, w_we, w_stall, w_pcsrc;
    logic [DW-1:0] w_addr, w_wdata;
    logic          w_memop, w_in_we;

    // MemRead takes priority if both memory bits are set.
    assign w_memop = i_m[1] | i_m[0];
    assign w_in_we = ~i_m[1] & i_m[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb      <= '0;
            r_rd      <= '0;
            r_wb_o    <= '0;
            r_rdata_o <= '0;
            r_alu_o   <= '0;
            r_rd_o    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_set_err) r_bus_err <= 1'b1;
            if (w_cap) begin
                r_we    <= w_in_we;
                r_addr  <= i_alu_result;
                r_wdata <= i_write_data;
                r_wb    <= i_wb;
                r_rd    <= i_rd;
            end
            r_wb_o    <= w_mw_wb;
            r_rdata_o <= w_mw_rdata;
            r_alu_o   <= w_mw_alu;
            r_rd_o    <= w_mw_rd;
        end
    end

    // The MEM/WB fields default to zero. That zero value is the bubble.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_set_err   = 1'b0;
        w_cap       = 1'b0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_stall     = 1'b0;
        w_pcsrc     = 1'b0;
        w_mw_wb     = '0;
        w_mw_rdata  = '0;
        w_mw_alu    = '0;
        w_mw_rd     = '0;
        unique case (r_state)
            IDLE: begin
                w_pcsrc = i_m[2] & i_zero;
                if (w_memop) begin
                    w_req   = 1'b1;
                    w_we    = w_in_we;
                    w_addr  = i_alu_result;
                    w_wdata = i_write_data;
                    if (dmem.ack) begin
                        w_mw_wb    = i_wb;
                        w_mw_rdata = w_in_we ? '0 : dmem.rdata;
                        w_mw_alu   = i_alu_result;
                        w_mw_rd    = i_rd;
                    end else begin
                        w_stall     = 1'b1;
                        w_cap       = 1'b1;
                        w_nxt_cnt   = CW'(1);
                        w_nxt_state = WAIT;
                    end
                end else begin
                    w_mw_wb  = i_wb;
                    w_mw_alu = i_alu_result;
                    w_mw_rd  = i_rd;
                end
            end
            WAIT: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                if (dmem.ack) begin
                    w_mw_wb     = r_wb;
                    w_mw_rdata  = r_we ? '0 : dmem.rdata;
                    w_mw_alu    = r_addr;
                    w_mw_rd     = r_rd;
                    w_nxt_cnt   = '0;
                    w_nxt_state = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_stall     = 1'b1;
                    w_set_err   = 1'b1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Reset drops the request at once, so a late ack is never consumed.
    assign dmem.req   = w_req & ~i_rst;
    assign dmem.we    = w_we;
    assign dmem.addr  = w_addr;
    assign dmem.wdata = w_wdata;
    assign o_stall    = w_stall & ~i_rst;
    assign o_pcsrc    = w_pcsrc & ~i_rst;

    assign o_bus_err    = r_bus_err;
    assign o_wb         = r_wb_o;
    assign o_read_data  = r_rdata_o;
    assign o_alu_result = r_alu_o;
    assign o_rd         = r_rd_o;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, zero-wait load, stalled
// store, load timeout, branch resolution and reset in the middle of a wait.
module tb_mem_stage_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wb;
    logic [2:0]    m;
    logic          zero;
    logic [4:0]    rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic          stall, pcsrc, bus_err;
    logic [1:0]    wb_o;
    logic [DW-1:0] rdata_o, alu_o;
    logic [4:0]    rd_o;

    int total = 0;
    int bad   = 0;

    mem_stage_ctrl_if #(.DW(DW)) dmem ();

    mem_stage_ctrl #(.DW(DW), .TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb         (wb),
        .i_m          (m),
        .i_zero       (zero),
        .i_rd         (rd),
        .i_alu_result (alu),
        .i_write_data (wdata),
        .dmem         (dmem.master),
        .o_stall      (stall),
        .o_pcsrc      (pcsrc),
        .o_bus_err    (bus_err),
        .o_wb         (wb_o),
        .o_read_data  (rdata_o),
        .o_alu_result (alu_o),
        .o_rd         (rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [2:0] mm, input logic z,
                         input logic [4:0] r, input logic [DW-1:0] a, input logic [DW-1:0] d);
        wb = w; m = mm; zero = z; rd = r; alu = a; wdata = d;
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        drive(2'b11, 3'b100, 1'b1, 5'd1, 32'h1, 32'h2);
        tick; tick;
        chk("rst_wb", wb_o, 2'b00);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_alu", alu_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_pcsrc", pcsrc, 0);
        drive(2'b11, 3'b010, 1'b0, 5'd1, 32'h1, 32'h2);
        chk("rst_req", dmem.req, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;

        // ALU operation flows straight through.
        drive(2'b10, 3'b000, 1'b0, 5'd5, 32'h1234, 32'h0);
        chk("alu_stall", stall, 0);
        chk("alu_req", dmem.req, 0);
        tick;
        chk("alu_wb", wb_o, 2'b10);
        chk("alu_res", alu_o, 32'h1234);
        chk("alu_rd", rd_o, 5);
        chk("alu_rdata", rdata_o, 0);

        // Load answered in the request cycle.
        drive(2'b11, 3'b010, 1'b0, 5'd6, 32'h40, 32'h0);
        dmem.ack = 1'b1; dmem.rdata = 32'hDEADBEEF; #1;
        chk("ld0_req", dmem.req, 1);
        chk("ld0_we", dmem.we, 0);
        chk("ld0_addr", dmem.addr, 32'h40);
        chk("ld0_stall", stall, 0);
        tick;
        dmem.ack = 1'b0; dmem.rdata = '0;
        chk("ld0_rdata", rdata_o, 32'hDEADBEEF);
        chk("ld0_wb", wb_o, 2'b11);
        chk("ld0_rd", rd_o, 6);

        // Store acked three cycles after the request; inputs change meanwhile.
        drive(2'b00, 3'b001, 1'b0, 5'd7, 32'h80, 32'hA5A5A5A5);
        chk("st_stall0", stall, 1);
        chk("st_we", dmem.we, 1);
        tick;
        drive(2'b11, 3'b000, 1'b0, 5'd9, 32'hFFFF, 32'h0);
        chk("st_stall1", stall, 1);
        chk("st_addr1", dmem.addr, 32'h80);
        chk("st_wdata1", dmem.wdata, 32'hA5A5A5A5);
        chk("st_we1", dmem.we, 1);
        chk("st_wb1", wb_o, 0);
        tick;
        chk("st_stall2", stall, 1);
        chk("st_wb2", wb_o, 0);
        tick;
        dmem.ack = 1'b1; #1;
        chk("st_stall3", stall, 0);
        chk("st_addr3", dmem.addr, 32'h80);
        tick;
        dmem.ack = 1'b0; #1;
        chk("st_alu_o", alu_o, 32'h80);
        chk("st_rd_o", rd_o, 7);
        chk("st_rdata_o", rdata_o, 0);
        chk("st_idle_stall", stall, 0);

        // Load that never gets an ack times out after 16 stalled cycles.
        drive(2'b11, 3'b010, 1'b0, 5'd9, 32'h100, 32'h0);
        n = 0;
        while (stall && n < 40) begin
            n++;
            tick;
            drive(2'b11, 3'b000, 1'b0, 5'd9, 32'h100, 32'h0);
        end
        chk("to_cycles", n, 16);
        chk("to_err", bus_err, 1);
        chk("to_req", dmem.req, 0);
        chk("to_wb", wb_o, 0);
        drive(2'b10, 3'b000, 1'b0, 5'd3, 32'h55, 32'h0);
        tick;
        chk("to_next_wb", wb_o, 2'b10);
        chk("to_next_alu", alu_o, 32'h55);
        chk("to_err_sticky", bus_err, 1);

        // Branch resolution.
        drive(2'b00, 3'b100, 1'b1, 5'd0, 32'h0, 32'h0);
        chk("br_taken", pcsrc, 1);
        drive(2'b00, 3'b100, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("br_not", pcsrc, 0);

        // A branch presented while waiting is not taken; then reset mid-wait.
        drive(2'b11, 3'b010, 1'b0, 5'd4, 32'h200, 32'h0);
        tick;
        drive(2'b00, 3'b100, 1'b1, 5'd0, 32'h0, 32'h0);
        chk("br_wait_pcsrc", pcsrc, 0);
        chk("br_wait_stall", stall, 1);
        rst = 1'b1; #1;
        chk("rw_req", dmem.req, 0);
        chk("rw_stall", stall, 0);
        chk("rw_pcsrc", pcsrc, 0);
        tick;
        drive(2'b00, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("rw_err", bus_err, 0);
        chk("rw_wb", wb_o, 0);
        rst = 1'b0;
        dmem.ack = 1'b1; dmem.rdata = 32'hCAFEF00D; #1;
        chk("rw_late_req", dmem.req, 0);
        chk("rw_late_stall", stall, 0);
        tick;
        dmem.ack = 1'b0;
        chk("rw_late_rdata", rdata_o, 0);
        chk("rw_late_wb", wb_o, 0);
        chk("rw_late_err", bus_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
